piso_tx_arbiter: RTL and testbench
==================================

PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

Interface
REQ-001 Parameter: WIDTH, default 3, meaning PISO word width in bits; legal range 2..15.
REQ-002 Ports SHALL be (clock and reset first):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  4  per-requester transfer request; held until acked.
- data_in  input  4*WIDTH  requester words; requester i at bits [i*WIDTH +: WIDTH].
- ack  output  4  one-cycle grant/acceptance pulse per requester.
- piso_load  output  1  load strobe to downstream PISO.
- piso_data  output  WIDTH  parallel word to downstream PISO.
- grant_id  output  2  index of the requester currently owning the PISO.
- busy  output  1  high in LOAD and SHIFT.
- bit_valid  output  1  PISO serial output carries a valid bit this cycle.
- bit_cnt  output  4  index of the current serial bit, 0..WIDTH-1.
- frame_done  output  1  pulse on the last valid bit of a word.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, LOAD, SHIFT.
REQ-004 IDLE: if any req bit is 1 at a rising edge, the FSM SHALL select a winner at that edge and enter LOAD; otherwise it SHALL remain in IDLE.
REQ-005 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and ascends with wrap; the first asserted req wins.
REQ-006 At the decision edge the block SHALL capture the winner's data_in slice into an internal register and set grant_id and last_grant to the winner.
REQ-007 LOAD lasts exactly 1 cycle, with piso_load=1, piso_data=captured word, ack[grant_id]=1, and all other ack bits 0.
REQ-008 piso_data SHALL be stable for the whole LOAD cycle; later changes to data_in SHALL NOT affect it.
REQ-009 SHIFT lasts exactly WIDTH cycles, with bit_valid=1 and bit_cnt counting 0,1,...,WIDTH-1, one step per cycle.
REQ-010 frame_done SHALL be 1 only in the SHIFT cycle where bit_cnt=WIDTH-1.
REQ-011 At the edge ending the last SHIFT cycle, the FSM SHALL arbitrate per REQ-005 and go to LOAD if any req is set, else to IDLE.
- Back-to-back words are therefore spaced exactly WIDTH+1 cycles apart.
REQ-012 Latency SHALL be: req sampled high at edge k in IDLE -> LOAD during cycle k+1 -> first valid bit during cycle k+2.
REQ-013 Outside SHIFT, bit_valid, bit_cnt and frame_done SHALL be 0; outside LOAD, piso_load and ack SHALL be 0.
REQ-014 grant_id SHALL hold its value through LOAD and SHIFT and SHALL retain its last value in IDLE.
REQ-015 A captured transfer SHALL always run to completion; dropping req after capture has no effect.
REQ-016 A req that drops before being sampled at a decision edge SHALL never be granted.
REQ-017 An acked requester's req still high at the next decision edge SHALL be treated as a new request, at round-robin priority.
REQ-018 piso_data in non-LOAD cycles SHALL hold the last captured word (0 after reset).

Reset
REQ-019 When reset=0, the block SHALL asynchronously and immediately enter IDLE and force all outputs to 0.
- Outputs forced to 0: ack, piso_load, piso_data, grant_id, busy, bit_valid, bit_cnt, frame_done.
REQ-020 Reset SHALL set last_grant=3 so that requester 0 has highest priority first; reset asserted mid-LOAD or mid-SHIFT SHALL abort the word.
REQ-021 After reset is released, the first decision SHALL occur at the first rising edge where reset=1.

Verification (WIDTH=3)
REQ-022 Reset: hold reset=0 for 2 cycles -> all outputs 0, busy=0.
REQ-023 Single request: req=0001, data_in[2:0]=101 -> next cycle piso_load=1, piso_data=101, ack=0001, grant_id=0; then 3 cycles with bit_valid=1 and bit_cnt=0,1,2; frame_done only at bit_cnt=2; then IDLE.
REQ-024 All four requesting: req=1111 held -> grant_id sequence 0,1,2,3,0 with piso_load every 4 cycles and no IDLE gap.
REQ-025 Round-robin continuation: after grant to 2 completes, req=1010 -> grant 3, then 1.
REQ-026 Reset mid-operation: reset=0 in the SHIFT cycle with bit_cnt=1 -> outputs 0 immediately; after release with req=1001, grant goes to 0 first.
REQ-027 Late or withdrawn request: req[2] pulsed during SHIFT and dropped before the last SHIFT edge -> ack[2] never asserts and the FSM returns to IDLE.

Source files
------------

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter that feeds one of four requesters' words into a downstream PISO.
// It issues one LOAD cycle per word, followed by WIDTH SHIFT cycles that carry the serial-bit status.
module piso_tx_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   data_in,
  output logic [3:0]           ack,
  output logic                 piso_load,
  output logic [WIDTH-1:0]     piso_data,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 bit_valid,
  output logic [3:0]           bit_cnt,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] winner;
  logic       any_req;
  logic       decide;

  // The search begins one past the last grant. On the fourth step it wraps back to the last grant itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner  = rr_pick(req, last_grant);
  assign any_req = |req;
  assign decide  = (state == IDLE) || (state == SHIFT && bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      ack        <= '0;
      piso_load  <= 1'b0;
      piso_data  <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      bit_valid  <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      ack        <= '0;
      piso_load  <= 1'b0;
      bit_valid  <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;

      unique case (state)
        LOAD: begin
          state     <= SHIFT;
          bit_valid <= 1'b1;
        end
        SHIFT: begin
          if (bit_cnt != LAST_BIT) begin
            bit_valid  <= 1'b1;
            bit_cnt    <= bit_cnt + 4'd1;
            frame_done <= (bit_cnt + 4'd1 == LAST_BIT);
          end
        end
        default: ;
      endcase

      // The decision edge is either an idle edge or the edge that ends the last serial bit.
      if (decide) begin
        if (any_req) begin
          state      <= LOAD;
          grant_id   <= winner;
          last_grant <= winner;
          piso_data  <= data_in[winner*WIDTH +: WIDTH];
          piso_load  <= 1'b1;
          ack        <= 4'b0001 << winner;
          busy       <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed and randomized checks of piso_tx_arbiter against a cycle-phase reference model.
module tb_piso_tx_arbiter;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     req = '0;
  logic [4*W-1:0] data_in = '0;
  logic [3:0]     ack;
  logic           piso_load;
  logic [W-1:0]   piso_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic           bit_valid;
  logic [3:0]     bit_cnt;
  logic           frame_done;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 = idle, 1 = load, 2..W+1 = serial bit (phase-2).
  int           m_phase = 0;
  int           m_last  = 3;
  int           m_gid   = 0;
  logic [W-1:0] m_word  = '0;

  piso_tx_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
    .piso_load(piso_load), .piso_data(piso_data), .grant_id(grant_id), .busy(busy),
    .bit_valid(bit_valid), .bit_cnt(bit_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 3; m_gid = 0; m_word = '0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [4*W-1:0] d);
    int w;
    if (m_phase == 0 || m_phase == W + 1) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
      if (w >= 0) begin
        m_phase = 1; m_gid = w; m_last = w; m_word = d[w*W +: W];
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase++;
    end
  endtask

  task automatic check_all();
    chk("ack",        ack,        (m_phase == 1) ? (32'd1 << m_gid) : 32'd0);
    chk("piso_load",  piso_load,  32'(m_phase == 1));
    chk("piso_data",  piso_data,  32'(m_word));
    chk("grant_id",   grant_id,   32'(m_gid));
    chk("busy",       busy,       32'(m_phase != 0));
    chk("bit_valid",  bit_valid,  32'(m_phase >= 2));
    chk("bit_cnt",    bit_cnt,    (m_phase >= 2) ? 32'(m_phase - 2) : 32'd0);
    chk("frame_done", frame_done, 32'(m_phase == W + 1));
  endtask

  // Drive inputs at the falling edge, advance the model on the rising edge, then compare.
  task automatic cyc(input logic [3:0] r, input logic rst_v, input logic [4*W-1:0] d);
    @(negedge clk);
    req = r; reset = rst_v; data_in = d;
    @(posedge clk);
    if (!rst_v) model_reset();
    else        model_step(r, d);
    #1 check_all();
  endtask

  task automatic rnd(input logic [3:0] r);
    cyc(r, 1'b1, 12'($urandom));
  endtask

  initial begin
    // Reset held for two cycles
    cyc(4'b0000, 1'b0, 12'($urandom));
    cyc(4'b0000, 1'b0, 12'($urandom));
    chk("rst_busy", busy, 32'd0);

    // Single request carrying word 101
    cyc(4'b0001, 1'b1, 12'h005);
    chk("single_data", piso_data, 32'h5);
    chk("single_ack", ack, 32'h1);
    for (int i = 0; i < W; i++) begin
      rnd(4'b0000);
      chk("single_cnt", bit_cnt, 32'(i));
      chk("single_fd", frame_done, 32'(i == W - 1));
    end
    rnd(4'b0000);
    chk("single_idle", busy, 32'd0);

    // All four requesting after reset: grants 0,1,2,3,0 with no gap
    cyc(4'b0000, 1'b0, 12'($urandom));
    for (int g = 0; g < 5; g++) begin
      rnd(4'b1111);
      chk("rr4_grant", grant_id, 32'(g % 4));
      chk("rr4_load", piso_load, 32'd1);
      for (int i = 0; i < W; i++) rnd(4'b1111);
    end

    // Grant 2 completes, then 1010 yields 3 then 1
    rnd(4'b0100);
    chk("cont_g2", grant_id, 32'd2);
    for (int i = 0; i < W; i++) rnd(4'b0000);
    rnd(4'b1010);
    chk("cont_g3", grant_id, 32'd3);
    for (int i = 0; i < W; i++) rnd(4'b1010);
    rnd(4'b1010);
    chk("cont_g1", grant_id, 32'd1);
    for (int i = 0; i < W + 1; i++) rnd(4'b0000);

    // Asynchronous reset in the SHIFT cycle with bit_cnt=1
    rnd(4'b0001);
    rnd(4'b0000);
    rnd(4'b0000);
    chk("mid_cnt", bit_cnt, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 model_reset();
    check_all();
    cyc(4'b1001, 1'b0, 12'($urandom));
    rnd(4'b1001);
    chk("post_rst_g0", grant_id, 32'd0);
    for (int i = 0; i < W; i++) rnd(4'b0000);
    rnd(4'b0000);

    // req[2] pulsed during SHIFT and dropped before the decision edge
    rnd(4'b0001);
    rnd(4'b0000);
    rnd(4'b0100);
    rnd(4'b0000);
    rnd(4'b0000);
    chk("late_idle", busy, 32'd0);
    chk("late_ack", ack, 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(63) == 0) cyc(4'($urandom), 1'b0, 12'($urandom));
      else                         rnd(4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
